// File: rtl/gate_sweep_checker.sv
// Self-test sequencer for the 2-input gates block: sweeps a/b through 00,01,10,11,
// waits a settle time, then checks y_and/y_or/y_xor and accumulates the results.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_and,
  input  logic             y_or,
  input  logic             y_xor,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_mask,
  output logic [1:0]       vec_idx
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             a_nxt, b_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [2:0]       mask_nxt, mism;
  logic [1:0]       vec_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_mask <= '0;
      vec_idx   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_cnt   <= err_nxt;
      fail_mask <= mask_nxt;
      vec_idx   <= vec_nxt;
    end
  end

  assign busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);

  // Expected gate outputs come from the registered stimulus, not from vec_idx.
  assign mism = {y_xor ^ (a ^ b), y_or ^ (a | b), y_and ^ (a & b)};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a;
    b_nxt     = b;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_cnt;
    mask_nxt  = fail_mask;
    vec_nxt   = vec_idx;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          err_nxt   = '0;
          mask_nxt  = '0;
          vec_nxt   = '0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        a_nxt     = vec_idx[1];
        b_nxt     = vec_idx[0];
        cnt_nxt   = '0;
        state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (cnt == CNT_LAST) state_nxt = CHECK;
        else                 cnt_nxt   = cnt + CNT_W'(1);
      end
      CHECK: begin
        mask_nxt = fail_mask | mism;
        // One error per failing vector, regardless of how many gates disagree.
        if ((mism != 3'b000) && (err_cnt != ERR_MAX)) err_nxt = err_cnt + ERR_W'(1);
        if (vec_idx == 2'd3) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == '0);
        end else begin
          vec_nxt   = vec_idx + 2'd1;
          state_nxt = DRIVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: two checkers (default and SETTLE_CYCLES=0/ERR_W=2) driven by
// fault-injectable gate models; a reference model predicts each sweep's result.
module tb_gate_sweep_checker;

  typedef struct {
    int   pass;
    int   err;
    int   mask;
    int   start_cyc;
  } exp_t;

  logic clk, rst_n, start;
  logic a0, b0, busy0, done0, pass0, y_and0, y_or0, y_xor0;
  logic [2:0] err0, mask0;
  logic [1:0] vec0;
  logic a1, b1, busy1, done1, pass1, y_and1, y_or1, y_xor1;
  logic [1:0] err1;
  logic [2:0] mask1;
  logic [1:0] vec1;
  logic [2:0] inv0, en0, val0, inv1, en1, val1;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q0[$];
  exp_t q1[$];

  gate_sweep_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .y_and(y_and0), .y_or(y_or0), .y_xor(y_xor0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_mask(mask0), .vec_idx(vec0)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(0), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .y_and(y_and1), .y_or(y_or1), .y_xor(y_xor1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_mask(mask1), .vec_idx(vec1)
  );

  // Gate models: each output either stuck at a value or the ideal function optionally inverted.
  assign y_and0 = en0[0] ? val0[0] : ((a0 & b0) ^ inv0[0]);
  assign y_or0  = en0[1] ? val0[1] : ((a0 | b0) ^ inv0[1]);
  assign y_xor0 = en0[2] ? val0[2] : ((a0 ^ b0) ^ inv0[2]);
  assign y_and1 = en1[0] ? val1[0] : ((a1 & b1) ^ inv1[0]);
  assign y_or1  = en1[1] ? val1[1] : ((a1 | b1) ^ inv1[1]);
  assign y_xor1 = en1[2] ? val1[2] : ((a1 ^ b1) ^ inv1[2]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] inv, input logic [2:0] en,
                                 input logic [2:0] val, input int err_w);
    exp_t e;
    int   n = 0;
    int   m = 0;
    for (int v = 0; v < 4; v++) begin
      int x = v / 2;
      int y = v % 2;
      int ideal[3];
      int fails = 0;
      ideal[0] = x & y;
      ideal[1] = x | y;
      ideal[2] = x ^ y;
      for (int g = 0; g < 3; g++) begin
        int got = en[g] ? int'(val[g]) : (ideal[g] ^ int'(inv[g]));
        if (got != ideal[g]) begin
          fails = 1;
          m = m | (1 << g);
        end
      end
      n += fails;
    end
    e.err       = (n > (1 << err_w) - 1) ? (1 << err_w) - 1 : n;
    e.pass      = (n == 0) ? 1 : 0;
    e.mask      = m;
    e.start_cyc = 0;
    return e;
  endfunction

  task automatic check_done(input string nm, input exp_t e, input int lat, input int act_pass,
                            input int act_err, input int act_mask, input int seqn,
                            input int bcnt, input int vi_ab);
    chk({nm, "_pass"}, act_pass, e.pass);
    chk({nm, "_err_cnt"}, act_err, e.err);
    chk({nm, "_fail_mask"}, act_mask, e.mask);
    chk({nm, "_latency"}, cyc - e.start_cyc, lat);
    chk({nm, "_ab_order"}, seqn, 4 * 256 + 8'h1B);
    chk({nm, "_busy_cycles"}, bcnt, lat);
    chk({nm, "_final_vec_ab"}, vi_ab, 4'hF);
  endtask

  // Monitor for dut0 (4 cycles per vector).
  initial begin
    int n = 0, bc = 0;
    logic [7:0] seq = '0;
    logic dprev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n = 0; bc = 0; seq = '0; dprev = 1'b0;
      end else begin
        if (busy0) begin
          bc++;
          if (n == 0 || {a0, b0} != seq[1:0]) begin
            seq = {seq[5:0], a0, b0};
            n++;
          end
        end
        if (done0 && !dprev) begin
          if (q0.size() == 0) begin
            chk("dut0_unexpected_done", 1, 0);
          end else begin
            e = q0.pop_front();
            check_done("dut0", e, 16, int'(pass0), int'(err0), int'(mask0), n * 256 + int'(seq),
                       bc, int'({vec0, a0, b0}));
          end
          n = 0; bc = 0; seq = '0;
        end
        dprev = done0;
      end
    end
  end

  // Monitor for dut1 (2 cycles per vector, 2-bit error counter).
  initial begin
    int n = 0, bc = 0;
    logic [7:0] seq = '0;
    logic dprev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n = 0; bc = 0; seq = '0; dprev = 1'b0;
      end else begin
        if (busy1) begin
          bc++;
          if (n == 0 || {a1, b1} != seq[1:0]) begin
            seq = {seq[5:0], a1, b1};
            n++;
          end
        end
        if (done1 && !dprev) begin
          if (q1.size() == 0) begin
            chk("dut1_unexpected_done", 1, 0);
          end else begin
            e = q1.pop_front();
            check_done("dut1", e, 8, int'(pass1), int'(err1), int'(mask1), n * 256 + int'(seq),
                       bc, int'({vec1, a1, b1}));
          end
          n = 0; bc = 0; seq = '0;
        end
        dprev = done1;
      end
    end
  end

  task automatic issue_start();
    exp_t e0, e1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = model(inv0, en0, val0, 3);
    e1 = model(inv1, en1, val1, 2);
    e0.start_cyc = cyc;
    e1.start_cyc = cyc;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // k>0 re-pulses start so that it is sampled k edges after the real start (both DUTs busy).
  task automatic sweep(input logic [2:0] i0, input logic [2:0] e0, input logic [2:0] v0,
                       input logic [2:0] i1, input logic [2:0] e1, input logic [2:0] v1,
                       input int k);
    inv0 = i0; en0 = e0; val0 = v0;
    inv1 = i1; en1 = e1; val1 = v1;
    issue_start();
    if (k > 0) begin
      repeat (k - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("sweep_complete", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    inv0 = '0; en0 = '0; val0 = '0;
    inv1 = '0; en1 = '0; val1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_dut0", int'({a0, b0, busy0, done0, pass0, err0, mask0, vec0}), 0);
    chk("reset_dut1", int'({a1, b1, busy1, done1, pass1, err1, mask1, vec1}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_without_start", int'({busy0, done0, busy1, done1}), 0);

    sweep(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    sweep(3'b000, 3'b100, 3'b000, 3'b111, 3'b000, 3'b000, 0);
    sweep(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 6);
    sweep(3'b010, 3'b001, 3'b001, 3'b000, 3'b011, 3'b000, 3);

    for (int r = 0; r < 20; r++) begin
      logic [2:0] ri0, re0, rv0, ri1, re1, rv1;
      int         rk;
      ri0 = 3'($urandom); re0 = 3'($urandom) & 3'($urandom); rv0 = 3'($urandom);
      ri1 = 3'($urandom); re1 = 3'($urandom) & 3'($urandom); rv1 = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin ri0 = '0; re0 = '0; end
      if ($urandom_range(0, 3) == 0) begin ri1 = '0; re1 = '0; end
      rk = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
      sweep(ri0, re0, rv0, ri1, re1, rv1, rk);
    end

    // Reset in the CHECK cycle of vector 2 on dut0, with every gate output inverted.
    inv0 = 3'b111; en0 = '0; val0 = '0;
    inv1 = '0; en1 = '0; val1 = '0;
    issue_start();
    repeat (11) @(posedge clk);
    #1;
    chk("pre_reset_busy", int'(busy0), 1);
    chk("pre_reset_err_cnt", int'(err0), 2);
    #1;
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("mid_reset_dut0", int'({a0, b0, busy0, done0, err0, mask0, vec0}), 0);
    chk("dut1_done_before_reset", q1.size(), 0);
    q1.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", int'({busy0, done0, a0, b0, err0, busy1, done1}), 0);

    sweep(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Sequential stimulus-and-check stage wrapped around the 2-input gates block (AND/OR/XOR).
- Drives a/b through all four input combinations in truth-table order.
- Waits a programmable settle time, then samples y_and/y_or/y_xor and compares them against internally computed expected values.
- Reports pass/fail, error count and a per-gate failure mask.
- Replaces hand-written stimulus for on-board self-test of the gates block.

Parameters:
SETTLE_CYCLES, 2, cycles held in SETTLE before sampling; 0 is legal and skips SETTLE.
ERR_W, 3, width of err_cnt; the counter saturates at 2^ERR_W-1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle start request.
y_and  input  1  AND output from gates block.
y_or  input  1  OR output from gates block.
y_xor  input  1  XOR output from gates block.
a  output  1  registered stimulus to gates block.
b  output  1  registered stimulus to gates block.
busy  output  1  high while a sweep is in progress.
done  output  1  high in DONE state.
pass  output  1  valid when done=1; 1 iff err_cnt==0.
err_cnt  output  ERR_W  number of failing vectors, saturating.
fail_mask  output  3  sticky per-gate mismatch {xor,or,and}.
vec_idx  output  2  current vector index, {a,b}.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - a, b, busy, done, pass, err_cnt, fail_mask and vec_idx all go to 0.
  - A reset mid-sweep aborts immediately; no partial result is retained.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE. busy=1 in DRIVE, SETTLE and CHECK.
- IDLE / DONE, start=1:
  - Clear err_cnt, fail_mask and vec_idx.
  - Set a=0, b=0, done=0, pass=0.
  - Go to DRIVE.
  - start=0: remain in the current state.
- DRIVE: one cycle. a=vec_idx[1], b=vec_idx[0] (registered). Go to SETTLE, or go straight to CHECK if SETTLE_CYCLES==0.
- SETTLE: counter runs 0..SETTLE_CYCLES-1, i.e. exactly SETTLE_CYCLES cycles. Then go to CHECK.
- CHECK: one cycle. Expected values: e_and=a&b, e_or=a|b, e_xor=a^b.
  - mism = {y_xor^e_xor, y_or^e_or, y_and^e_and}.
  - fail_mask |= mism.
  - If mism is nonzero, err_cnt increments by 1, once per vector rather than once per gate, and holds at its maximum value.
  - If vec_idx==3, go to DONE; otherwise vec_idx++ and go to DRIVE.
- DONE:
  - done=1; pass=(err_cnt==0), registered on entry.
  - a, b, err_cnt and fail_mask hold.
  - Stays in DONE until the next start.
- start while busy is ignored; it is not queued.
- Latency:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - done rises 4*(SETTLE_CYCLES+2) cycles after the clock edge that samples start.
  - With defaults this is 16 cycles.
- Inputs y_* are treated as combinational functions of a/b. They are sampled only in CHECK and ignored in every other state.
- Vector order is 00, 01, 10, 11. vec_idx wraps only via restart, never by increment past 3.

Test Plan:
- Correct gates block, defaults. Pulse start → a/b sequence 00,01,10,11 with each value held 4 cycles; done=1 at start+16; pass=1, err_cnt=0, fail_mask=000.
- y_xor stuck at 0 → vectors 01 and 10 fail; err_cnt=2, fail_mask=3'b100, pass=0.
- All three outputs inverted, with ERR_W=2 → every vector fails; err_cnt saturates at 3; fail_mask=3'b111.
- start re-pulsed during SETTLE of vector 1 → ignored; the sweep still completes at start+16 with unchanged results. A new start while in DONE clears the counters and reruns the sweep.
- rst_n low mid-CHECK of vector 2 → a, b, busy and err_cnt go to 0 immediately; after release the block sits in IDLE until start.
- SETTLE_CYCLES=0 → 2 cycles per vector; done at start+8, pass=1.
